// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: reset/trap vectors, nop
// encoding, PC-source selector and the IF/ID register layout.
package fetch_stage_pkg;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_IRQ_VECTOR   = 32'h0000_0004;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0008;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_JMP,
        SRC_JR,
        SRC_BR,
        SRC_IRQ,
        SRC_EXC
    } pc_src_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    // j/jal target: region bits of the jump's own PC+4, then the word index.
    function automatic logic [31:0] jump_target(input logic [3:0]  region,
                                                input logic [25:0] index);
        return {region, index, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_next_pc_sel.sv
// Next-PC priority mux: picks the redirect source, flags an IF/ID flush and
// tells the PC/IF-ID registers whether to hold for a stall.
module next_pc_sel
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] IRQ_VECTOR = DEF_IRQ_VECTOR,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic [31:0] pc_plus4,
    input  logic [3:0]  pc_region,
    input  logic        stall,
    input  logic        jump_taken,
    input  logic [25:0] jump_index,
    input  logic        jr_taken,
    input  logic [31:0] jr_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        interrupt,
    input  logic        exception,
    output logic [31:0] next_pc,
    output logic        flush,
    output logic        hold
);

    pc_src_e src;

    // Older pipeline stages win: an EX redirect makes any ID jump wrong-path.
    always_comb begin
        src = SRC_SEQ;
        if (exception)         src = SRC_EXC;
        else if (interrupt)    src = SRC_IRQ;
        else if (branch_taken) src = SRC_BR;
        else if (jr_taken)     src = SRC_JR;
        else if (jump_taken)   src = SRC_JMP;
    end

    always_comb begin
        next_pc = pc_plus4;
        unique case (src)
            SRC_EXC: next_pc = EXC_VECTOR;
            SRC_IRQ: next_pc = IRQ_VECTOR;
            SRC_BR:  next_pc = branch_target;
            SRC_JR:  next_pc = jr_target;
            SRC_JMP: next_pc = jump_target(pc_region, jump_index);
            default: next_pc = pc_plus4;
        endcase
    end

    // Any redirect discards the stalled ID instruction, so stall only holds
    // when fetch would otherwise be sequential.
    assign flush = (src != SRC_SEQ);
    assign hold  = stall && !flush;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, IF/ID pipeline register and the
// count of instructions accepted into decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] IRQ_VECTOR   = DEF_IRQ_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] PC,
    input  logic [31:0] Instruction,
    input  logic        Stall,
    input  logic        JumpTaken,
    input  logic [25:0] JumpIndex,
    input  logic        JrTaken,
    input  logic [31:0] JrTarget,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Interrupt,
    input  logic        Exception,
    output logic [31:0] IF_ID_Instr,
    output logic [31:0] IF_ID_PC4,
    output logic        IF_ID_Valid,
    output logic [31:0] FetchCount
);

    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        flush;
    logic        hold;
    if_id_t      if_id;

    assign pc_plus4 = PC + 32'd4;

    next_pc_sel #(
        .IRQ_VECTOR (IRQ_VECTOR),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_pc_sel (
        .pc_plus4      (pc_plus4),
        .pc_region     (if_id.pc4[31:28]),
        .stall         (Stall),
        .jump_taken    (JumpTaken),
        .jump_index    (JumpIndex),
        .jr_taken      (JrTaken),
        .jr_target     (JrTarget),
        .branch_taken  (BranchTaken),
        .branch_target (BranchTarget),
        .interrupt     (Interrupt),
        .exception     (Exception),
        .next_pc       (next_pc),
        .flush         (flush),
        .hold          (hold)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC         <= RESET_VECTOR;
            if_id      <= '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};
            FetchCount <= 32'h0;
        end else if (!hold) begin
            PC <= next_pc;
            if (flush) begin
                if_id <= '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};
            end else begin
                if_id      <= '{instr: Instruction, pc4: pc_plus4, valid: 1'b1};
                FetchCount <= FetchCount + 32'd1;
            end
        end
    end

    assign IF_ID_Instr = if_id.instr;
    assign IF_ID_PC4   = if_id.pc4;
    assign IF_ID_Valid = if_id.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed boot/stall/redirect/wrap/reset
// scenarios followed by randomized redirect and stall traffic.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic        Stall = 1'b0;
    logic        JumpTaken = 1'b0;
    logic [25:0] JumpIndex = '0;
    logic        JrTaken = 1'b0;
    logic [31:0] JrTarget = '0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = '0;
    logic        Interrupt = 1'b0;
    logic        Exception = 1'b0;
    logic [31:0] IF_ID_Instr;
    logic [31:0] IF_ID_PC4;
    logic        IF_ID_Valid;
    logic [31:0] FetchCount;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .PC           (PC),
        .Instruction  (Instruction),
        .Stall        (Stall),
        .JumpTaken    (JumpTaken),
        .JumpIndex    (JumpIndex),
        .JrTaken      (JrTaken),
        .JrTarget     (JrTarget),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Interrupt    (Interrupt),
        .Exception    (Exception),
        .IF_ID_Instr  (IF_ID_Instr),
        .IF_ID_PC4    (IF_ID_PC4),
        .IF_ID_Valid  (IF_ID_Valid),
        .FetchCount   (FetchCount)
    );

    // Boot image: word 0 jumps to word 3; other words are address-tagged.
    function automatic logic [31:0] imem(input logic [31:0] addr);
        if (addr == 32'h0) return 32'h0800_0003;
        return {8'h24, addr[23:0]} ^ 32'h0055_AA00;
    endfunction

    assign Instruction = imem(PC);

    // Reference: architectural fetch state advanced once per clock.
    logic [31:0] m_pc = 32'h0, m_instr = 32'h0, m_pc4 = 32'h0, m_count = 32'h0;
    logic        m_valid = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_count = 32'h0;
        end else begin
            logic redirect;
            logic [31:0] tgt;
            redirect = 1'b1;
            tgt = 32'h0;
            if (Exception)        tgt = 32'h8;
            else if (Interrupt)   tgt = 32'h4;
            else if (BranchTaken) tgt = BranchTarget;
            else if (JrTaken)     tgt = JrTarget;
            else if (JumpTaken)   tgt = (m_pc4 & 32'hF000_0000) | ({6'd0, JumpIndex} * 4);
            else                  redirect = 1'b0;
            if (redirect) begin
                m_pc = tgt; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            end else if (!Stall) begin
                m_instr = imem(m_pc);
                m_pc4   = m_pc + 4;
                m_valid = 1'b1;
                m_count = m_count + 1;
                m_pc    = m_pc4;
            end
        end
    end

    always @(negedge clk) begin
        checks++;
        if (PC !== m_pc || IF_ID_Instr !== m_instr || IF_ID_PC4 !== m_pc4 ||
            IF_ID_Valid !== m_valid || FetchCount !== m_count) begin
            failures++;
            $display("FAIL model_cmp t=%0t got pc=%h ins=%h pc4=%h v=%b cnt=%0d want pc=%h ins=%h pc4=%h v=%b cnt=%0d",
                     $time, PC, IF_ID_Instr, IF_ID_PC4, IF_ID_Valid, FetchCount,
                     m_pc, m_instr, m_pc4, m_valid, m_count);
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_in();
        Stall = 1'b0; JumpTaken = 1'b0; JrTaken = 1'b0; BranchTaken = 1'b0;
        Interrupt = 1'b0; Exception = 1'b0;
    endtask

    initial begin
        step(); step();
        lit("rst_pc", PC, 32'h0);
        lit("rst_instr", IF_ID_Instr, 32'h0);
        lit("rst_pc4", IF_ID_PC4, 32'h0);
        lit("rst_valid", {31'd0, IF_ID_Valid}, 32'h0);
        lit("rst_count", FetchCount, 32'h0);

        // Boot: fetch word 0, then decode its jump to 0xC.
        reset = 1'b0;
        step();
        lit("boot_pc", PC, 32'h4);
        lit("boot_instr", IF_ID_Instr, 32'h0800_0003);
        lit("boot_pc4", IF_ID_PC4, 32'h4);
        lit("boot_count", FetchCount, 32'd1);
        JumpTaken = 1'b1; JumpIndex = 26'd3;
        step();
        clear_in();
        lit("jmp_pc", PC, 32'hC);
        lit("jmp_flush", {31'd0, IF_ID_Valid}, 32'h0);
        lit("jmp_count", FetchCount, 32'd1);

        // Stall at 0x14 for two cycles.
        step(); step();
        lit("pre_stall_pc", PC, 32'h14);
        Stall = 1'b1;
        step(); step();
        lit("stall_pc", PC, 32'h14);
        lit("stall_pc4", IF_ID_PC4, 32'h14);
        lit("stall_instr", IF_ID_Instr, imem(32'h10));
        lit("stall_count", FetchCount, 32'd3);
        Stall = 1'b0;
        step();
        lit("resume_pc", PC, 32'h18);
        lit("resume_count", FetchCount, 32'd4);

        // Branch beats a same-cycle jump.
        BranchTaken = 1'b1; BranchTarget = 32'h50; JumpTaken = 1'b1; JumpIndex = 26'h3FF;
        step();
        clear_in();
        lit("br_pc", PC, 32'h50);
        lit("br_flush", {31'd0, IF_ID_Valid}, 32'h0);

        // Exception > interrupt, both override stall; then interrupt alone.
        Exception = 1'b1; Interrupt = 1'b1; Stall = 1'b1;
        step();
        clear_in();
        lit("exc_pc", PC, 32'h8);
        lit("exc_flush", {31'd0, IF_ID_Valid}, 32'h0);
        Interrupt = 1'b1;
        step();
        clear_in();
        lit("irq_pc", PC, 32'h4);

        // PC wrap.
        JrTaken = 1'b1; JrTarget = 32'hFFFF_FFFC; JumpTaken = 1'b1;
        step();
        clear_in();
        lit("jr_pc", PC, 32'hFFFF_FFFC);
        step();
        lit("wrap_pc", PC, 32'h0);
        lit("wrap_pc4", IF_ID_PC4, 32'h0);
        lit("wrap_valid", {31'd0, IF_ID_Valid}, 32'h1);
        lit("wrap_instr", IF_ID_Instr, imem(32'hFFFF_FFFC));

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            Exception    = ($urandom_range(99) < 3);
            Interrupt    = ($urandom_range(99) < 3);
            BranchTaken  = ($urandom_range(99) < 8);
            JrTaken      = ($urandom_range(99) < 6);
            JumpTaken    = ($urandom_range(99) < 8);
            Stall        = ($urandom_range(99) < 25);
            BranchTarget = $urandom;
            JrTarget     = $urandom;
            JumpIndex    = 26'($urandom);
            step();
        end
        clear_in();
        step();

        // Asynchronous reset in the middle of a branch redirect.
        BranchTaken = 1'b1; BranchTarget = 32'h77;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        lit("async_pc", PC, 32'h0);
        lit("async_valid", {31'd0, IF_ID_Valid}, 32'h0);
        lit("async_count", FetchCount, 32'h0);
        lit("async_pc4", IF_ID_PC4, 32'h0);
        clear_in();
        step();
        reset = 1'b0;
        step();
        lit("post_rst_pc", PC, 32'h4);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
